// File: rtl/simt_diverge_ctrl_pkg.sv
// Shared types for the SIMT divergence controller: branch op codes, FSM states
// and the default lane count taken from `N_CORES.
`ifndef N_CORES
`define N_CORES 4
`endif

package simt_pkg;

  localparam int unsigned N_LANES_DEF = `N_CORES;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_IF    = 2'd1,
    OP_ELSE  = 2'd2,
    OP_ENDIF = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

endpackage

// File: rtl/simt_diverge_ctrl_if.sv
// Issue-side branch-op handshake plus fetch-side redirect request, bundled for
// the divergence controller (slave) and its issue/fetch partners (master).
interface simt_diverge_ctrl_if #(
  parameter int unsigned N_LANES = simt_pkg::N_LANES_DEF,
  parameter int unsigned PC_W    = 8
);
  import simt_pkg::*;

  logic               op_valid;
  logic               op_ready;
  op_e                op_code;
  logic [N_LANES-1:0] lane_cond;
  logic [PC_W-1:0]    skip_pc;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               redirect_ack;

  modport master (
    output op_valid, op_code, lane_cond, skip_pc, redirect_ack,
    input  op_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  op_valid, op_code, lane_cond, skip_pc, redirect_ack,
    output op_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/simt_diverge_ctrl_mask_stack.sv
// DEPTH-entry LIFO of W-bit mask entries; push-when-full and pop-when-empty are
// silently dropped. top reads zero when the stack is empty.
module mask_stack #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  d,
  output logic [W-1:0]  top,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0] mem [DEPTH];

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (CW'(i) == count) mem[i] <= d;
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (CW'(i + 1) == count) top = mem[i];
  end

endmodule

// File: rtl/simt_diverge_ctrl.sv
// SIMT divergence controller: sequences IF/ELSE/ENDIF over a per-warp mask stack
// and requests a fetch redirect when a path has no active lane.
// Optional statistics counters are built when DIVERGE_STATS_EN is defined.
module simt_diverge_ctrl
  import simt_pkg::*;
#(
  parameter int unsigned N_LANES = N_LANES_DEF,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  simt_diverge_ctrl_if.slave           bus,
  output logic [N_LANES-1:0]           active_mask,
  output logic                         all_true,
  output logic                         all_false,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         err_overflow,
  output logic                         err_underflow,
  output logic [15:0]                  stat_diverge,
  output logic [15:0]                  stat_skip
);

  state_e             state;
  op_e                op_q;
  logic [N_LANES-1:0] cond_q;
  logic [PC_W-1:0]    pc_q;

  logic                 push, pop, full, empty;
  logic [2*N_LANES-1:0] top;
  logic [N_LANES-1:0]   top_parent, top_cond, cond_mask, new_mask;
  logic                 mask_upd, set_ovf, set_unf, redir_go;

  mask_stack #(.W(2 * N_LANES), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .d     ({active_mask, cond_mask}),
    .top   (top),
    .full  (full),
    .empty (empty),
    .count (depth)
  );

  assign top_parent = top[2*N_LANES-1:N_LANES];
  assign top_cond   = top[N_LANES-1:0];
  assign cond_mask  = active_mask & cond_q;
  assign all_true   = &active_mask;
  assign all_false  = ~|active_mask;

  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    mask_upd = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    new_mask = active_mask;
    if (state == ST_EXEC) begin
      case (op_q)
        OP_IF: begin
          if (full) set_ovf = 1'b1;
          else begin
            push     = 1'b1;
            mask_upd = 1'b1;
            new_mask = cond_mask;
          end
        end
        OP_ELSE: begin
          if (empty) set_unf = 1'b1;
          else begin
            mask_upd = 1'b1;
            new_mask = top_parent & ~top_cond;
          end
        end
        OP_ENDIF: begin
          if (empty) set_unf = 1'b1;
          else begin
            pop      = 1'b1;
            mask_upd = 1'b1;
            new_mask = top_parent;
          end
        end
        default: ;
      endcase
    end
    // ENDIF never redirects even if it restores an empty parent path
    redir_go = mask_upd && (new_mask == '0) && (op_q == OP_IF || op_q == OP_ELSE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      op_q               <= OP_NOP;
      cond_q             <= '0;
      pc_q               <= '0;
      active_mask        <= '1;
      err_overflow       <= 1'b0;
      err_underflow      <= 1'b0;
      bus.op_ready       <= 1'b1;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.op_valid) begin
            op_q         <= bus.op_code;
            cond_q       <= bus.lane_cond;
            pc_q         <= bus.skip_pc;
            bus.op_ready <= 1'b0;
            state        <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (mask_upd) active_mask <= new_mask;
          if (set_ovf) err_overflow <= 1'b1;
          if (set_unf) err_underflow <= 1'b1;
          if (redir_go) begin
            bus.redirect_valid <= 1'b1;
            bus.redirect_pc    <= pc_q;
            state              <= ST_REDIR;
          end else begin
            bus.op_ready <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        ST_REDIR: begin
          if (bus.redirect_ack) begin
            bus.redirect_valid <= 1'b0;
            bus.op_ready       <= 1'b1;
            state              <= ST_IDLE;
          end
        end
        default: begin
          bus.op_ready <= 1'b1;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DIVERGE_STATS_EN
  logic divergent;
  assign divergent = push && (cond_mask != '0) && (cond_mask != active_mask);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_diverge <= '0;
      stat_skip    <= '0;
    end else begin
      if (divergent && stat_diverge != '1) stat_diverge <= stat_diverge + 16'd1;
      if (redir_go && stat_skip != '1) stat_skip <= stat_skip + 16'd1;
    end
  end
`else
  assign stat_diverge = '0;
  assign stat_skip    = '0;
`endif

endmodule

// File: tb/tb_simt_diverge_ctrl.sv
// Directed self-checking bench for simt_diverge_ctrl with N_LANES=4, DEPTH=2.
module tb_simt_diverge_ctrl;
  import simt_pkg::*;

`ifdef DIVERGE_STATS_EN
  localparam int unsigned STATS = 1;
`else
  localparam int unsigned STATS = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] active_mask;
  logic       all_true, all_false;
  logic [1:0] depth;
  logic       err_overflow, err_underflow;
  logic [15:0] stat_diverge, stat_skip;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  simt_diverge_ctrl_if #(.N_LANES(4), .PC_W(8)) bus ();

  simt_diverge_ctrl #(.N_LANES(4), .DEPTH(2), .PC_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .active_mask   (active_mask),
    .all_true      (all_true),
    .all_false     (all_false),
    .depth         (depth),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .stat_diverge  (stat_diverge),
    .stat_skip     (stat_skip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one op at a negedge; returns 1ns after the EXEC edge.
  task automatic do_op(input op_e op, input logic [3:0] cond, input logic [7:0] pc);
    @(negedge clk);
    check("ready_before_op", bus.op_ready, 1);
    bus.op_valid  = 1'b1;
    bus.op_code   = op;
    bus.lane_cond = cond;
    bus.skip_pc   = pc;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    check("ready_low_exec", bus.op_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    bus.redirect_ack = 1'b1;
    @(posedge clk); #1;
    bus.redirect_ack = 1'b0;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] mask, input logic [1:0] dep,
                              input logic rv, input logic rdy);
    check({tag, "_mask"},  active_mask, mask);
    check({tag, "_depth"}, depth, dep);
    check({tag, "_rv"},    bus.redirect_valid, rv);
    check({tag, "_ready"}, bus.op_ready, rdy);
  endtask

  initial begin
    bus.op_valid     = 1'b0;
    bus.op_code      = OP_NOP;
    bus.lane_cond    = '0;
    bus.skip_pc      = '0;
    bus.redirect_ack = 1'b0;

    // 1: reset release
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    expect_state("rst", 4'b1111, 2'd0, 1'b0, 1'b1);
    check("rst_all_true",  all_true, 1);
    check("rst_all_false", all_false, 0);
    check("rst_rpc",       bus.redirect_pc, 0);
    check("rst_ovf",       err_overflow, 0);
    check("rst_unf",       err_underflow, 0);
    check("rst_stat_div",  stat_diverge, 0);

    // NOP changes nothing; ack outside REDIR ignored
    do_op(OP_NOP, 4'b0000, 8'h11);
    expect_state("nop", 4'b1111, 2'd0, 1'b0, 1'b1);
    pulse_ack();
    expect_state("stray_ack", 4'b1111, 2'd0, 1'b0, 1'b1);

    // 2: IF / ELSE / ENDIF
    do_op(OP_IF, 4'b0101, 8'h10);
    expect_state("if1", 4'b0101, 2'd1, 1'b0, 1'b1);
    check("if1_all_true", all_true, 0);
    do_op(OP_ELSE, 4'b0000, 8'h12);
    expect_state("else1", 4'b1010, 2'd1, 1'b0, 1'b1);
    do_op(OP_ENDIF, 4'b0000, 8'h00);
    expect_state("endif1", 4'b1111, 2'd0, 1'b0, 1'b1);
    check("stat_div_1", stat_diverge, STATS);

    // 3: empty IF path redirects and holds until ack
    do_op(OP_IF, 4'b0000, 8'h20);
    expect_state("redir", 4'b0000, 2'd1, 1'b1, 1'b0);
    check("redir_pc", bus.redirect_pc, 8'h20);
    check("redir_all_false", all_false, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      expect_state("redir_hold", 4'b0000, 2'd1, 1'b1, 1'b0);
      check("redir_hold_pc", bus.redirect_pc, 8'h20);
    end
    pulse_ack();
    expect_state("redir_ack", 4'b0000, 2'd1, 1'b0, 1'b1);
    do_op(OP_ENDIF, 4'b0000, 8'h00);
    expect_state("redir_endif", 4'b1111, 2'd0, 1'b0, 1'b1);

    // 4: nesting
    do_op(OP_IF, 4'b0011, 8'h30);
    expect_state("nest_if1", 4'b0011, 2'd1, 1'b0, 1'b1);
    do_op(OP_IF, 4'b0001, 8'h31);
    expect_state("nest_if2", 4'b0001, 2'd2, 1'b0, 1'b1);
    do_op(OP_ELSE, 4'b0000, 8'h32);
    expect_state("nest_else", 4'b0010, 2'd2, 1'b0, 1'b1);
    do_op(OP_ENDIF, 4'b0000, 8'h00);
    expect_state("nest_endif2", 4'b0011, 2'd1, 1'b0, 1'b1);
    do_op(OP_ENDIF, 4'b0000, 8'h00);
    expect_state("nest_endif1", 4'b1111, 2'd0, 1'b0, 1'b1);
    check("stat_div_3", stat_diverge, 3 * STATS);

    // 5: overflow / underflow
    do_op(OP_IF, 4'b1111, 8'h40);
    do_op(OP_IF, 4'b1111, 8'h41);
    check("ovf_pre", err_overflow, 0);
    do_op(OP_IF, 4'b1111, 8'h42);
    expect_state("ovf", 4'b1111, 2'd2, 1'b0, 1'b1);
    check("ovf_flag", err_overflow, 1);
    do_op(OP_ENDIF, 4'b0000, 8'h00);
    do_op(OP_ENDIF, 4'b0000, 8'h00);
    check("unf_pre", err_underflow, 0);
    do_op(OP_ENDIF, 4'b0000, 8'h00);
    expect_state("unf", 4'b1111, 2'd0, 1'b0, 1'b1);
    check("unf_flag", err_underflow, 1);

    // ELSE with an empty complement also redirects; errors stay sticky
    do_op(OP_IF, 4'b1111, 8'h50);
    do_op(OP_ELSE, 4'b0000, 8'h60);
    expect_state("else_redir", 4'b0000, 2'd1, 1'b1, 1'b0);
    check("else_redir_pc", bus.redirect_pc, 8'h60);
    pulse_ack();
    do_op(OP_ENDIF, 4'b0000, 8'h00);
    expect_state("else_redir_done", 4'b1111, 2'd0, 1'b0, 1'b1);
    check("ovf_sticky", err_overflow, 1);
    check("unf_sticky", err_underflow, 1);
    check("stat_div_end", stat_diverge, 3 * STATS);
    check("stat_skip_end", stat_skip, 2 * STATS);

    // 6: async reset mid-REDIR
    do_op(OP_IF, 4'b0000, 8'h33);
    check("pre_rst_rv", bus.redirect_valid, 1);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    expect_state("async_rst", 4'b1111, 2'd0, 1'b0, 1'b1);
    check("async_rst_rpc", bus.redirect_pc, 0);
    check("async_rst_ovf", err_overflow, 0);
    check("async_rst_unf", err_underflow, 0);
    check("async_rst_stat", stat_skip, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    expect_state("post_rst", 4'b1111, 2'd0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
